// File: rtl/avmm_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to SHA3 core bridge.
// FIFO entries are sized for the widest legal bus; the top trims them.
package avmm_bridge_pkg;

   localparam int MAX_ADDR_W      = 32;
   localparam int MAX_DATA_W      = 64;
   localparam int MAX_RD_INFLIGHT = 2;

   typedef struct packed {
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] data;
   } wfifo_entry_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/avmm_wfifo.sv
// Posted-write FIFO: pointers wrap modulo DEPTH, level counts 0..DEPTH.
// A pop never frees space for a push in the same cycle.
module avmm_wfifo
   import avmm_bridge_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  wfifo_entry_t          push_data,
   input  logic                  pop,
   output wfifo_entry_t          pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level
);

   localparam int PW = clog2(DEPTH);

   wfifo_entry_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full     = (level == (PW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/avmm_sha3_bridge.sv
// Avalon-MM slave bridge to the SHA3 register core: posted writes via a
// FIFO, registered pipelined reads returned with readdatavalid.
module avmm_sha3_bridge
   import avmm_bridge_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_W-1:0]           avs_s0_address,
   input  logic                        avs_s0_read,
   input  logic                        avs_s0_write,
   input  logic [DATA_W-1:0]           avs_s0_writedata,
   output logic [DATA_W-1:0]           avs_s0_readdata,
   output logic                        avs_s0_readdatavalid,
   output logic                        avs_s0_waitrequest,
   output logic                        core_cs,
   output logic                        core_we,
   output logic [ADDR_W-1:0]           core_address,
   output logic [DATA_W-1:0]           core_write_data,
   input  logic [DATA_W-1:0]           core_read_data,
   input  logic                        core_status_valid,
   output logic [clog2(WFIFO_DEPTH):0] wfifo_level,
   output logic                        proto_err
);

   logic              wr_acc;
   logic              rd_acc;
   logic              fifo_full;
   logic              fifo_empty;
   logic              rd_pend;
   logic [ADDR_W-1:0] rd_addr;
   wfifo_entry_t      push_e;
   wfifo_entry_t      pop_e;

   // Reads need an empty FIFO, which keeps them behind earlier writes.
   assign wr_acc = avs_s0_write && !fifo_full;
   assign rd_acc = avs_s0_read && !avs_s0_write && fifo_empty
                   && core_status_valid;

   assign avs_s0_waitrequest = !rst_n
      || ((avs_s0_read || avs_s0_write) && !(wr_acc || rd_acc));

   always_comb begin
      push_e      = '0;
      push_e.addr = MAX_ADDR_W'(avs_s0_address);
      push_e.data = MAX_DATA_W'(avs_s0_writedata);
   end

   avmm_wfifo #(
      .DEPTH     (WFIFO_DEPTH)
   ) u_wfifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_acc),
      .push_data (push_e),
      .pop       (!fifo_empty),
      .pop_data  (pop_e),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (wfifo_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend              <= 1'b0;
         rd_addr              <= '0;
         core_cs              <= 1'b0;
         core_we              <= 1'b0;
         core_address         <= '0;
         core_write_data      <= '0;
         avs_s0_readdata      <= '0;
         avs_s0_readdatavalid <= 1'b0;
         proto_err            <= 1'b0;
      end else begin
         rd_pend   <= rd_acc;
         proto_err <= proto_err || (avs_s0_read && avs_s0_write);
         if (rd_acc) rd_addr <= avs_s0_address;

         avs_s0_readdatavalid <= core_cs && !core_we;
         if (core_cs && !core_we) avs_s0_readdata <= core_read_data;

         if (!fifo_empty) begin
            core_cs         <= 1'b1;
            core_we         <= 1'b1;
            core_address    <= ADDR_W'(pop_e.addr);
            core_write_data <= DATA_W'(pop_e.data);
         end else if (rd_pend) begin
            core_cs      <= 1'b1;
            core_we      <= 1'b0;
            core_address <= rd_addr;
         end else begin
            core_cs <= 1'b0;
            core_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_avmm_sha3_bridge.sv
// Scoreboard bench: transaction-level model predicts accepts, FIFO
// occupancy, core writes/reads and read data; a monitor checks outputs.
module tb_avmm_sha3_bridge;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int D  = 4;

   typedef struct {
      int          a;
      logic [63:0] d;
      int          c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] address = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [DW-1:0] writedata = '0;
   logic [DW-1:0] readdata;
   logic          rdv;
   logic          wreq;
   logic          core_cs;
   logic          core_we;
   logic [AW-1:0] core_address;
   logic [DW-1:0] core_write_data;
   logic [DW-1:0] core_read_data;
   logic          sv = 1'b0;
   logic [2:0]    level;
   logic          perr;

   logic [DW-1:0] core_mem [256];
   logic [DW-1:0] ref_mem  [256];

   exp_t q_cw[$];
   exp_t q_cr[$];
   exp_t q_rd[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int cnt = 0;
   int last_cw = 0;
   logic perr_m = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avmm_sha3_bridge #(
      .DATA_W(DW), .ADDR_W(AW), .WFIFO_DEPTH(D)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .avs_s0_address       (address),
      .avs_s0_read          (read),
      .avs_s0_write         (write),
      .avs_s0_writedata     (writedata),
      .avs_s0_readdata      (readdata),
      .avs_s0_readdatavalid (rdv),
      .avs_s0_waitrequest   (wreq),
      .core_cs              (core_cs),
      .core_we              (core_we),
      .core_address         (core_address),
      .core_write_data      (core_write_data),
      .core_read_data       (core_read_data),
      .core_status_valid    (sv),
      .wfifo_level          (level),
      .proto_err            (perr)
   );

   // Register-file model of the SHA3 core
   assign core_read_data = core_mem[core_address];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) core_mem[i] <= '0;
      end else if (core_cs && core_we) begin
         core_mem[core_address] <= core_write_data;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: compares every core access and read return with the queues
   always @(negedge clk) begin
      exp_t e;
      if (core_cs === 1'b1) begin
         if (core_we) begin
            if (q_cw.size() == 0) chk("core_wr_unexpected", 1, 0);
            else begin
               e = q_cw.pop_front();
               chk("core_wr_addr", 64'(core_address), 64'(e.a));
               chk("core_wr_data", 64'(core_write_data), e.d);
               chk("core_wr_cycle", 64'(cyc), 64'(e.c));
            end
         end else begin
            if (q_cr.size() == 0) chk("core_rd_unexpected", 1, 0);
            else begin
               e = q_cr.pop_front();
               chk("core_rd_addr", 64'(core_address), 64'(e.a));
               chk("core_rd_cycle", 64'(cyc), 64'(e.c));
            end
         end
      end
      if (rdv === 1'b1) begin
         if (q_rd.size() == 0) chk("rdv_unexpected", 1, 0);
         else begin
            e = q_rd.pop_front();
            chk("readdata", 64'(readdata), e.d);
            chk("rdv_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s,
                       output logic acc);
      logic ew;
      logic er;
      int   c;
      int   p;
      read = r; write = w; address = a; writedata = d; sv = s;
      @(negedge clk);
      ew = w && (cnt < D);
      er = r && !w && (cnt == 0) && s;
      chk("waitrequest", 64'(wreq), 64'((r || w) ? !(ew || er) : 1'b0));
      chk("wfifo_level", 64'(level), 64'(cnt));
      chk("proto_err", 64'(perr), 64'(perr_m));
      if (ew) begin
         c = (cyc + 2 > last_cw + 1) ? cyc + 2 : last_cw + 1;
         last_cw = c;
         q_cw.push_back('{int'(a), 64'(d), c});
         ref_mem[a] = d;
      end
      if (er) begin
         q_cr.push_back('{int'(a), 64'(0), cyc + 2});
         q_rd.push_back('{int'(a), 64'(ref_mem[a]), cyc + 3});
      end
      if (r && w) perr_m = 1'b1;
      p = (cnt > 0) ? 1 : 0;
      cnt = cnt + (ew ? 1 : 0) - p;
      acc = ew || er;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s);
      logic acc;
      int   n;
      n = 0;
      do begin
         step(r, w, a, d, s, acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 1'b1, acc);
   endtask

   task automatic do_reset(input int n);
      read = 0; write = 0;
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("wait_in_reset", 64'(wreq), 1);
         @(posedge clk);
      end
      #1;
      rst_n = 1'b1;
      q_cw.delete(); q_cr.delete(); q_rd.delete();
      cnt = 0; perr_m = 1'b0; last_cw = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      @(negedge clk);
      chk("rst_core_cs", 64'(core_cs), 0);
      chk("rst_core_we", 64'(core_we), 0);
      chk("rst_core_addr", 64'(core_address), 0);
      chk("rst_core_wdata", 64'(core_write_data), 0);
      chk("rst_readdata", 64'(readdata), 0);
      chk("rst_rdv", 64'(rdv), 0);
      chk("rst_level", 64'(level), 0);
      chk("rst_proto_err", 64'(perr), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic acc;
      logic r;
      logic w;
      do_reset(3);

      // single write
      xfer(0, 1, 8'h10, 32'hDEADBEEF, 1);
      idle(3);

      // fill with status low: six back-to-back writes
      for (int i = 0; i < 6; i++) begin
         xfer(0, 1, AW'(8'h30 + i), 32'hA000_0000 + i, 0);
         chk("level_max", 64'(level <= 3'(D)), 1);
      end
      idle(8);

      // read after write to the same address
      xfer(0, 1, 8'h20, 32'h1234_5678, 1);
      xfer(1, 0, 8'h20, '0, 1);
      idle(4);

      // status stall for 5 cycles, then release
      for (int i = 0; i < 5; i++) step(1, 0, 8'h20, '0, 0, acc);
      xfer(1, 0, 8'h20, '0, 1);
      idle(4);

      // back-to-back reads
      xfer(1, 0, 8'h10, '0, 1);
      xfer(1, 0, 8'h31, '0, 1);
      xfer(1, 0, 8'h20, '0, 1);
      idle(4);

      // simultaneous read and write
      xfer(1, 1, 8'h04, 32'h0000_0444, 1);
      idle(4);
      do_reset(1);
      idle(2);

      // reset mid-drain
      xfer(0, 1, 8'h01, 32'h11, 0);
      xfer(0, 1, 8'h02, 32'h22, 0);
      xfer(0, 1, 8'h03, 32'h33, 0);
      do_reset(1);
      idle(5);

      // randomized traffic
      for (int t = 0; t < 1500; t++) begin
         int k;
         int n;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         k = int'($urandom_range(0, 9));
         a = AW'($urandom_range(0, 15));
         d = $urandom;
         r = (k < 4);
         w = (k >= 4 && k < 8);
         n = 0;
         do begin
            step(r, w, a, d, ($urandom_range(0, 4) != 0), acc);
            n++;
         end while ((r || w) && !acc && n < 50);
         if ((r || w) && !acc) chk("rand_accept_timeout", 0, 1);
      end
      idle(10);
      chk("q_cw_drained", 64'(q_cw.size()), 0);
      chk("q_cr_drained", 64'(q_cr.size()), 0);
      chk("q_rd_drained", 64'(q_rd.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
